prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter INIT_CYCLES, default 2: cycles core_init is held high per launch; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of the cycle counter and timeout limit.
REQ-003 Parameter TIMEOUT, default 16'hFFFF: cycle limit while waiting for ack; used only when PROG_SEQ_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 init  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  host launch request; sampled only in IDLE or DONE.
REQ-007 abort  input  1  host abort; returns the sequencer to IDLE.
REQ-008 core_init  output  1  drives processor init.
REQ-009 core_req  output  1  drives processor req.
REQ-010 core_ack  input  1  processor ack (level; stays high until the core is re-initialised).
REQ-011 busy  output  1  high in INIT, REQ and WAIT.
REQ-012 done  output  1  high in DONE.
REQ-013 timed_out  output  1  high in DONE when the run ended by timeout.
REQ-014 cycles  output  CNT_W  cycles from core_req assertion to ack detection.
REQ-015 run_cnt  output  8  completed runs since reset, including timed-out runs.

Function
REQ-016 FSM states: IDLE, INIT, REQ, WAIT, DONE; all outputs registered.
REQ-017 IDLE: on start=1, go to INIT, load init counter with INIT_CYCLES, and clear cycles and timed_out.
REQ-018 INIT: core_init=1; decrement the counter each cycle.
- Exit to REQ when the counter reaches 0 and core_ack=0.
- While the counter is 0 and core_ack=1, stay in INIT with core_init held high (stale-ack extension).
REQ-019 REQ: core_req=1 for exactly one cycle, core_init=0; go to WAIT; cycles starts at 1.
REQ-020 WAIT: cycles increments each cycle and saturates at 2^CNT_W-1 (no wrap).
- On core_ack=1, go to DONE; cycles keeps the value from the detecting cycle.
REQ-021 DONE: done=1; cycles, timed_out and run_cnt stay stable; run_cnt increments once on DONE entry and wraps 255->0.
REQ-022 DONE plus start=1 behaves as IDLE plus start=1 (relaunch); done drops the cycle after start is sampled.
REQ-023 start is ignored while busy=1; no queuing.
REQ-024 abort=1 in any state returns the FSM to IDLE next cycle with core_init=0, core_req=0, run_cnt unchanged and cycles cleared.
- abort takes priority over start and core_ack in the same cycle.
REQ-025 core_ack=1 in WAIT on the same cycle cycles reaches TIMEOUT: ack wins and timed_out=0.
REQ-026 core_ack is ignored in IDLE, REQ and DONE.

Reset
REQ-027 init=1 on a rising edge, including mid-run, SHALL force: state=IDLE, core_init=0, core_req=0, busy=0, done=0, timed_out=0, cycles=0, run_cnt=0, init counter=0.
REQ-028 start and abort are ignored in any cycle where init=1.

Configuration
REQ-029 With PROG_SEQ_TIMEOUT_EN defined:
- In WAIT, when cycles equals TIMEOUT and core_ack=0, go to DONE with timed_out=1.
- cycles is held at TIMEOUT on that exit.
REQ-030 Without PROG_SEQ_TIMEOUT_EN: WAIT exits only on core_ack or abort; timed_out is tied to 0; the TIMEOUT parameter is unused.

Verification
REQ-031 Reset, start=1 one cycle, core_ack rises 5 cycles after the core_req pulse:
- core_init high exactly 2 cycles, then core_req high 1 cycle.
- done=1, cycles=6, run_cnt=1.
REQ-032 core_ack held high through INIT: core_init stays high until ack drops; core_req pulses the cycle after the drop.
REQ-033 start pulsed in WAIT: no effect; then a relaunch from DONE runs normally and run_cnt=2.
REQ-034 abort and core_ack both high in WAIT: state=IDLE next cycle, done=0, run_cnt unchanged, cycles=0.
REQ-035 Timeout (PROG_SEQ_TIMEOUT_EN defined, TIMEOUT=10, ack never rises): done=1, timed_out=1, cycles=10.
- Same stimulus without the macro: still busy after 1000 cycles.
REQ-036 init asserted in WAIT with cycles=3: next cycle all outputs at reset values, and a subsequent start launches normally.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: launch/ack handshake sequencer for a processor core (PROG_SEQ_TIMEOUT_EN adds a WAIT timeout)
module prog_sequencer #(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 16'hFFFF
)(
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic             abort,
  output logic             core_init,
  output logic             core_req,
  input  logic             core_ack,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycles,
  output logic [7:0]       run_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state, next_state;
  logic [7:0] init_cnt, init_cnt_d, run_cnt_d;
  logic [CNT_W-1:0] cycles_d, cyc_inc;
  logic core_init_d, core_req_d, busy_d, done_d, timed_out_d, to_hit;
`ifdef PROG_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  assign to_hit = cycles == TO_LIM;
`else
  assign to_hit = 1'b0;
`endif
  assign cyc_inc = &cycles ? cycles : cycles + CNT_W'(1);
  // state register; every output is a flop loaded from its next value
  always_ff @(posedge clk)
    if (init) begin
      state     <= S_IDLE;
      core_init <= 1'b0;
      core_req  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      cycles    <= '0;
      run_cnt   <= '0;
      init_cnt  <= '0;
    end else begin
      state     <= next_state;
      core_init <= core_init_d;
      core_req  <= core_req_d;
      busy      <= busy_d;
      done      <= done_d;
      timed_out <= timed_out_d;
      cycles    <= cycles_d;
      run_cnt   <= run_cnt_d;
      init_cnt  <= init_cnt_d;
    end
  // next state: abort beats everything; INIT holds on a stale ack once the counter is spent
  always_comb begin
    next_state = state;
    if (abort)
      next_state = S_IDLE;
    else
      case (state)
        S_IDLE, S_DONE: next_state = start ? S_INIT : state;
        S_INIT:         next_state = (init_cnt <= 8'd1 && !core_ack) ? S_REQ : S_INIT;
        S_REQ:          next_state = S_WAIT;
        S_WAIT:         next_state = (core_ack || to_hit) ? S_DONE : S_WAIT;
        default:        next_state = S_IDLE;
      endcase
  end
  // next output values; cycles counts from the req cycle (1) and freezes on DONE entry
  always_comb begin
    core_init_d = next_state == S_INIT;
    core_req_d  = next_state == S_REQ;
    busy_d      = next_state == S_INIT || next_state == S_REQ || next_state == S_WAIT;
    done_d      = next_state == S_DONE;
    init_cnt_d  = (state != S_INIT && next_state == S_INIT) ? 8'(INIT_CYCLES) :
                  (state == S_INIT && init_cnt != 8'd0) ? init_cnt - 8'd1 : init_cnt;
    cycles_d    = next_state == S_REQ ? CNT_W'(1) : next_state == S_WAIT ? cyc_inc :
                  next_state == S_DONE ? cycles : '0;
    run_cnt_d   = (state == S_WAIT && next_state == S_DONE) ? run_cnt + 8'd1 : run_cnt;
    timed_out_d = (state == S_WAIT && next_state == S_DONE) ? !core_ack :
                  next_state == S_DONE ? timed_out : 1'b0;
  end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: scoreboard bench for prog_sequencer (CNT_W=4, TIMEOUT=10)
module tb_prog_sequencer;
  logic clk = 1'b0, init = 1'b1, start = 1'b0, abort = 1'b0, core_ack = 1'b0;
  logic core_init, core_req, busy, done, timed_out;
  logic [3:0] cycles;
  logic [7:0] run_cnt;
  typedef struct packed {logic [3:0] cyc; logic to; logic [7:0] rc;} exp_t;
  exp_t sb[$];
  logic [7:0] exp_runs = 8'd0;
  int vectors = 0, miscompares = 0;

  prog_sequencer #(.INIT_CYCLES(2), .CNT_W(4), .TIMEOUT(10)) dut (
    .clk(clk), .init(init), .start(start), .abort(abort), .core_init(core_init),
    .core_req(core_req), .core_ack(core_ack), .busy(busy), .done(done),
    .timed_out(timed_out), .cycles(cycles), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done;
    int w;
    exp_t e;
    w = 0;
    while (done !== 1'b1 && w < 40) begin
      tick;
      w++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, w);
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty: DONE reached with no expected run queued");
    end else begin
      e = sb.pop_front();
      if ({cycles, timed_out, run_cnt, busy} !== {e.cyc, e.to, e.rc, 1'b0}) begin
        miscompares++;
        $display("FAIL run_result: cycles=%0d timed_out=%b run_cnt=%0d busy=%b, required cycles=%0d timed_out=%b run_cnt=%0d busy=0",
                 cycles, timed_out, run_cnt, busy, e.cyc, e.to, e.rc);
      end
    end
  endtask

  task automatic launch(input int stale, input int ack_delay, input bit poke);
    exp_t e;
    int n;
    e.cyc = 4'(ack_delay + 1);
    e.to = 1'b0;
    e.rc = exp_runs + 8'd1;
    exp_runs = e.rc;
    sb.push_back(e);
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (core_init === 1'b1 && n < 50) begin
      n++;
      if (n == 2 + stale) core_ack = 1'b0;
      tick;
    end
    vectors++;
    if (n != 2 + stale) begin
      miscompares++;
      $display("FAIL init_len: core_init high %0d cycles, required %0d", n, 2 + stale);
    end
    vectors++;
    if ({core_req, core_init, cycles} !== {1'b1, 1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL req_pulse: req=%b init=%b cycles=%0d, required req=1 init=0 cycles=1", core_req, core_init, cycles);
    end
    for (int k = 1; k <= ack_delay; k++) begin
      tick;
      if (k == 1) begin
        vectors++;
        if ({core_req, busy} !== 2'b01) begin
          miscompares++;
          $display("FAIL req_width: req=%b busy=%b, required req=0 busy=1", core_req, busy);
        end
      end
      if (poke && k == 2) start = 1'b1;
      if (poke && k == 3) start = 1'b0;
      if (k == ack_delay) core_ack = 1'b1;
    end
    wait_done;
  endtask

  task automatic test_reset;
    tick;
    tick;
    vectors++;
    if ({core_init, core_req, busy, done, timed_out, cycles, run_cnt} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs=%h, required 0", {core_init, core_req, busy, done, timed_out, cycles, run_cnt});
    end
    init = 1'b0;
    tick;
    vectors++;
    if ({core_init, core_req, busy, done, timed_out, cycles, run_cnt} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_idle: outputs=%h, required 0", {core_init, core_req, busy, done, timed_out, cycles, run_cnt});
    end
  endtask

  task automatic test_basic;
    launch(0, 5, 1'b0);
  endtask

  task automatic test_stale_ack;
    launch(3, 3, 1'b0);
  endtask

  task automatic test_start_in_wait;
    launch(2, 4, 1'b1);
  endtask

  task automatic test_back_to_back;
    launch(2, 9, 1'b0);
    tick;
    tick;
    tick;
    vectors++;
    if ({done, busy, cycles, run_cnt} !== {1'b1, 1'b0, 4'd10, exp_runs}) begin
      miscompares++;
      $display("FAIL done_stable: done=%b busy=%b cycles=%0d run_cnt=%0d, required 1 0 10 %0d", done, busy, cycles, run_cnt, exp_runs);
    end
  endtask

  task automatic test_abort;
    core_ack = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    abort = 1'b1;
    core_ack = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    core_ack = 1'b0;
    vectors++;
    if ({core_init, core_req, busy, done, cycles, run_cnt} !== {5'b0, 4'd0, exp_runs}) begin
      miscompares++;
      $display("FAIL abort_idle: init=%b req=%b busy=%b done=%b cycles=%0d run_cnt=%0d, required 0 0 0 0 0 %0d",
               core_init, core_req, busy, done, cycles, run_cnt, exp_runs);
    end
    core_ack = 1'b1;
    tick;
    tick;
    core_ack = 1'b0;
    vectors++;
    if ({busy, done, run_cnt} !== {2'b00, exp_runs}) begin
      miscompares++;
      $display("FAIL idle_ack: busy=%b done=%b run_cnt=%0d, required 0 0 %0d", busy, done, run_cnt, exp_runs);
    end
    launch(0, 1, 1'b0);
  endtask

  task automatic test_timeout;
    core_ack = 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
    exp_runs = exp_runs + 8'd1;
    sb.push_back('{cyc: 4'd10, to: 1'b1, rc: exp_runs});
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done;
`else
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (1000) tick;
    vectors++;
    if ({busy, done, timed_out, cycles} !== {3'b100, 4'd15}) begin
      miscompares++;
      $display("FAIL no_timeout: busy=%b done=%b timed_out=%b cycles=%0d, required 1 0 0 15", busy, done, timed_out, cycles);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    vectors++;
    if ({busy, cycles, run_cnt} !== {1'b0, 4'd0, exp_runs}) begin
      miscompares++;
      $display("FAIL abort_wait: busy=%b cycles=%0d run_cnt=%0d, required 0 0 %0d", busy, cycles, run_cnt, exp_runs);
    end
`endif
  endtask

  task automatic test_init_midrun;
    core_ack = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    vectors++;
    if ({busy, cycles} !== {1'b1, 4'd3}) begin
      miscompares++;
      $display("FAIL wait_cnt: busy=%b cycles=%0d, required 1 3", busy, cycles);
    end
    init = 1'b1;
    start = 1'b1;
    tick;
    init = 1'b0;
    start = 1'b0;
    exp_runs = 8'd0;
    vectors++;
    if ({core_init, core_req, busy, done, timed_out, cycles, run_cnt} !== 17'd0) begin
      miscompares++;
      $display("FAIL init_midrun: outputs=%h, required 0", {core_init, core_req, busy, done, timed_out, cycles, run_cnt});
    end
    launch(0, 4, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stale_ack;
    test_start_in_wait;
    test_back_to_back;
    test_abort;
    test_timeout;
    test_init_midrun;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d expected runs never completed, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
